// File: rtl/circuit_sweeper.sv
// Stimulus-and-capture sweeper: walks {a,b,c,d} through 0..15, samples f_in after a
// settle delay and builds a truth table. Optional check: `define CIRCUIT_SWEEPER_CHECK_EN.
module circuit_sweeper #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);
    // With no settle delay each vector goes straight to its sampling cycle.
    localparam logic [1:0] ST_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    logic [1:0] state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       capture;
    logic       clear;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    idx_nxt   = 4'd0;
                    cnt_nxt   = SETTLE_CNT;
                    state_nxt = ST_ENTRY;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    idx_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt <= 8'd1) state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // abort wins over the capture scheduled for this edge
                if (abort) begin
                    idx_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    if (idx == 4'd15) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx + 4'd1;
                        cnt_nxt   = SETTLE_CNT;
                        state_nxt = ST_ENTRY;
                    end
                end
            end
            default: begin
                idx_nxt   = 4'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 4'd0;
            cnt       <= 8'd0;
            table_out <= 16'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            if (clear)        table_out      <= 16'd0;
            else if (capture) table_out[idx] <= f_in;
        end
    end

`ifdef CIRCUIT_SWEEPER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 pass <= 1'b0;
        else if (clear)             pass <= 1'b0;
        else if (state == ST_DONE)  pass <= (table_out == expected);
    end
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign pass = 1'b0;
`endif

    assign {a, b, c, d} = idx;
    assign busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done         = (state == ST_DONE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_circuit_sweeper.sv
// Bench for circuit_sweeper: three instances (SETTLE=1,0,3) with directed sweeps;
// sweep results are pushed to per-instance queues and checked by done-driven monitors.
module tb_circuit_sweeper;

`ifdef CIRCUIT_SWEEPER_CHECK_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif
    localparam int W = 25; // {latency[7:0], pass, table[15:0]}

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance u1 (SETTLE=1)
    logic start1, abort1, fin1;
    logic [15:0] exp1, table1;
    logic a1, b1, c1, d1, busy1, done1, pass1;
    logic [1:0] st1;
    int mode; // 0: real circuit, 1: idx[0], 2: constant 1
    assign fin1 = (mode == 0) ? ({a1, b1} == {c1, d1}) : (mode == 1) ? d1 : 1'b1;

    // instances u0 (SETTLE=0) and u3 (SETTLE=3), f_in = idx[0]
    logic start0, start3, abort_off;
    logic [15:0] exp03, table0, table3;
    logic a0, b0, c0, d0, busy0, done0, pass0;
    logic a3, b3, c3, d3, busy3, done3, pass3;
    logic [1:0] st0, st3;

    circuit_sweeper #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(fin1),
        .expected(exp1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(table1), .pass(pass1), .state_dbg(st1));
    circuit_sweeper #(.SETTLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort_off), .f_in(d0),
        .expected(exp03), .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_out(table0), .pass(pass0), .state_dbg(st0));
    circuit_sweeper #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort_off), .f_in(d3),
        .expected(exp03), .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .table_out(table3), .pass(pass3), .state_dbg(st3));

    logic [W-1:0] exp_q1[$], exp_q0[$], exp_q3[$];
    logic [W-1:0] e1, e0, e3;
    int st1_cyc, st0_cyc, st3_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input int lat, input logic p, input logic [15:0] t);
        return {8'(lat), p, t};
    endfunction

    // Monitors: on each done pulse pop the expected entry; pass is visible one cycle later.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (exp_q1.size() == 0) chk("u1_unexpected_done", 32'd1, 32'd0);
            else begin
                e1 = exp_q1.pop_front();
                chk("u1_table", 32'(table1), 32'(e1[15:0]));
                chk("u1_latency", 32'(cyc - st1_cyc), 32'(e1[24:17]));
                chk("u1_busy_in_done", 32'(busy1), 32'd0);
                @(negedge clk);
                chk("u1_pass", 32'(pass1), 32'(e1[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (exp_q0.size() == 0) chk("u0_unexpected_done", 32'd1, 32'd0);
            else begin
                e0 = exp_q0.pop_front();
                chk("u0_table", 32'(table0), 32'(e0[15:0]));
                chk("u0_latency", 32'(cyc - st0_cyc), 32'(e0[24:17]));
                @(negedge clk);
                chk("u0_pass", 32'(pass0), 32'(e0[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done3) begin
            if (exp_q3.size() == 0) chk("u3_unexpected_done", 32'd1, 32'd0);
            else begin
                e3 = exp_q3.pop_front();
                chk("u3_table", 32'(table3), 32'(e3[15:0]));
                chk("u3_latency", 32'(cyc - st3_cyc), 32'(e3[24:17]));
                @(negedge clk);
                chk("u3_pass", 32'(pass3), 32'(e3[16]));
            end
        end
    end

    task automatic start_u1();
        start1  = 1'b1;
        st1_cyc = cyc;
        @(negedge clk);
        start1 = 1'b0;
        chk("u1_busy_rise", 32'(busy1), 32'd1);
        chk("u1_table_clear", 32'(table1), 32'd0);
        chk("u1_pass_clear", 32'(pass1), 32'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q1.size() + exp_q0.size() + exp_q3.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((exp_q1.size() + exp_q0.size() + exp_q3.size()) != 0) begin
            chk("done_timeout", 32'(exp_q1.size() + exp_q0.size() + exp_q3.size()), 32'd0);
            exp_q1.delete();
            exp_q0.delete();
            exp_q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; start3 = 1'b0;
        abort_off = 1'b0; mode = 0; exp1 = 16'h8421; exp03 = 16'hAAAA;
        repeat (3) @(negedge clk);
        chk("reset_u1", 32'({a1, b1, c1, d1, busy1, done1, pass1, table1}), 32'd0);
        chk("reset_u0", 32'({a0, b0, c0, d0, busy0, done0, pass0, table0}), 32'd0);
        chk("reset_u3", 32'({a3, b3, c3, d3, busy3, done3, pass3, table3}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a sweep clears everything without a clock edge
        start_u1();
        repeat (9) @(negedge clk);
        chk("mid_sweep_busy", 32'(busy1), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({a1, b1, c1, d1, busy1, done1, pass1, table1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // real circuit: F=1 iff {a,b}=={c,d}
        mode = 0; exp1 = 16'h8421;
        exp_q1.push_back(pack(33, CK, 16'h8421));
        start_u1();
        wait_drain(200);
        chk("idle_outputs", 32'({a1, b1, c1, d1, busy1}), 32'd0);

        exp1 = 16'h8420;
        exp_q1.push_back(pack(33, 1'b0, 16'h8421));
        start_u1();
        wait_drain(200);

        // SETTLE=0 and SETTLE=3 with f_in = idx[0]
        exp_q0.push_back(pack(17, CK, 16'hAAAA));
        exp_q3.push_back(pack(65, CK, 16'hAAAA));
        start0 = 1'b1; start3 = 1'b1; st0_cyc = cyc; st3_cyc = cyc;
        @(negedge clk);
        start0 = 1'b0; start3 = 1'b0;
        wait_drain(300);

        // abort in the SAMPLE cycle of idx=5 (cycle after edge 11)
        mode = 2; exp1 = 16'h001F;
        start_u1();
        repeat (11) @(negedge clk);
        chk("abort_at_sample5_idx", 32'({a1, b1, c1, d1}), 32'd5);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_table", 32'(table1), 32'h001F);
        chk("abort_outputs", 32'({a1, b1, c1, d1, busy1, done1, pass1}), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_table_hold", 32'(table1), 32'h001F);

        // start pulses during the sweep and in the DONE cycle are ignored
        mode = 0; exp1 = 16'h8421;
        exp_q1.push_back(pack(33, CK, 16'h8421));
        start_u1();
        for (int i = 2; i <= 34; i++) begin
            @(negedge clk);
            start1 = ((i % 7) == 3) || (i == 33);
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_restart_busy", 32'(busy1), 32'd0);
        chk("no_restart_table", 32'(table1), 32'h8421);
        wait_drain(50);

        // fresh sweep afterwards clears the old table
        mode = 1; exp1 = 16'hAAAA;
        exp_q1.push_back(pack(33, CK, 16'hAAAA));
        start_u1();
        wait_drain(200);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
